// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the CPU bus gate arbiter.
//   bus_arb_state_t : arbiter FSM states
//   GATE_*          : Gate bit positions of each bus driver when N=4
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } bus_arb_state_t;

    localparam int unsigned GATE_PC     = 3;
    localparam int unsigned GATE_MDR    = 2;
    localparam int unsigned GATE_ALU    = 1;
    localparam int unsigned GATE_MARMUX = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   : per-driver request vector
//   owner_i : index of the current/last owner; scanning starts just above it
//   pick_o  : index of the first set request found, wrapping, owner scanned last
//   any_o   : 1 when any request is set (pick_o is only meaningful then)
module rr_pick #(
    parameter int unsigned N      = 4,
    parameter int unsigned OwnerW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      req_i,
    input  logic [OwnerW-1:0] owner_i,
    output logic [OwnerW-1:0] pick_o,
    output logic              any_o
);

    assign any_o = |req_i;

    always_comb begin
        logic        found;
        int unsigned idx;
        pick_o = '0;
        found  = 1'b0;
        idx    = 0;
        // Offsets 1..N so the owner itself (offset N) is considered last.
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(owner_i) + i) % N;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                pick_o = idx[OwnerW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner sequencer for the shared 16-bit CPU bus.
//   clk_i         : system clock, all state on rising edge
//   rst_n_i       : asynchronous active-low reset
//   req_i         : per-driver request, held while the bus is wanted
//   gate_o        : registered one-hot bus select, all-zero leaves the bus undriven
//   grant_valid_o : registered, 1 iff gate_o != 0
//   owner_o       : index of current/last owner
//   hold_cnt_o    : cycles the current owner has held the bus, saturating at MAX_HOLD
module bus_gate_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned TURNAROUND = 1,
    localparam int unsigned OwnerW    = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned HoldW     = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N-1:0]      req_i,
    output logic [N-1:0]      gate_o,
    output logic              grant_valid_o,
    output logic [OwnerW-1:0] owner_o,
    output logic [HoldW-1:0]  hold_cnt_o
);

    localparam logic [HoldW-1:0] MaxHold = HoldW'(MAX_HOLD);
    localparam logic [N-1:0]     OneBit  = N'(1);

    bus_arb_state_t    state_q, state_d;
    logic [N-1:0]      gate_q, gate_d;
    logic              gv_q;
    logic [OwnerW-1:0] owner_q, owner_d;
    logic [HoldW-1:0]  hold_q, hold_d;

    logic [N-1:0]      owner_oh, others, pick_req;
    logic [OwnerW-1:0] pick;
    logic              pick_any;
    logic              release_bus;

    assign owner_oh = OneBit << owner_q;
    assign others   = req_i & ~owner_oh;
    // In GRANT the picker only ever chooses a successor, so the owner is masked out.
    assign pick_req = (state_q == GRANT) ? others : req_i;

    assign release_bus = !req_i[owner_q] || ((others != '0) && (hold_q == MaxHold));

    rr_pick #(
        .N      (N),
        .OwnerW (OwnerW)
    ) u_pick (
        .req_i   (pick_req),
        .owner_i (owner_q),
        .pick_o  (pick),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gate_d  = OneBit << pick;
                    owner_d = pick;
                    hold_d  = HoldW'(1);
                end else begin
                    state_d = IDLE;
                    gate_d  = '0;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!release_bus) begin
                    if (hold_q != MaxHold) begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end else if (TURNAROUND != 0) begin
                    // Dead cycle: owner kept so the next scan starts after it.
                    state_d = TURN;
                    gate_d  = '0;
                    hold_d  = '0;
                end else if (pick_any) begin
                    gate_d  = OneBit << pick;
                    owner_d = pick;
                    hold_d  = HoldW'(1);
                end else begin
                    state_d = IDLE;
                    gate_d  = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gate_q  <= '0;
            gv_q    <= 1'b0;
            owner_q <= OwnerW'(N - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            gv_q    <= |gate_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    assign gate_o        = gate_q;
    assign grant_valid_o = gv_q;
    assign owner_o       = owner_q;
    assign hold_cnt_o    = hold_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Scoreboard bench for bus_gate_arbiter.
// Three instances: A (MAX_HOLD=8, TURNAROUND=1), B (MAX_HOLD=2, TURNAROUND=1),
// C (MAX_HOLD=8, TURNAROUND=0). Stimulus pushes the expected post-edge outputs,
// a monitor pops and compares them after the edge they are due on.
module tb_bus_gate_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] gate_a, gate_b, gate_c;
    logic       gv_a, gv_b, gv_c;
    logic [1:0] owner_a, owner_b, owner_c;
    logic [3:0] hold_a, hold_c;
    logic [1:0] hold_b;

    always #5 clk = ~clk;

    bus_gate_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(1)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .gate_o(gate_a),
        .grant_valid_o(gv_a), .owner_o(owner_a), .hold_cnt_o(hold_a)
    );
    bus_gate_arbiter #(.N(4), .MAX_HOLD(2), .TURNAROUND(1)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .gate_o(gate_b),
        .grant_valid_o(gv_b), .owner_o(owner_b), .hold_cnt_o(hold_b)
    );
    bus_gate_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(0)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_c), .gate_o(gate_c),
        .grant_valid_o(gv_c), .owner_o(owner_c), .hold_cnt_o(hold_c)
    );

    typedef struct {
        int         dut;
        int         due;
        logic [3:0] gate;
        logic [1:0] owner;
        logic [3:0] hold;
        bit         chk_hold;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply a request vector just after an edge; expected values describe the next edge.
    // h < 0 means hold count is not checked.
    task automatic step(input int dut, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] o, input int h, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        case (dut)
            0:       req_a = r;
            1:       req_b = r;
            default: req_c = r;
        endcase
        e.dut      = dut;
        e.due      = cyc + 1;
        e.gate     = g;
        e.owner    = o;
        e.hold     = 4'(h);
        e.chk_hold = (h >= 0);
        e.name     = name;
        sb.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] ag, ah;
        logic       agv;
        logic [1:0] ao;
        #3;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin ag = gate_a; agv = gv_a; ao = owner_a; ah = hold_a; end
                1:       begin ag = gate_b; agv = gv_b; ao = owner_b; ah = {2'b00, hold_b}; end
                default: begin ag = gate_c; agv = gv_c; ao = owner_c; ah = hold_c; end
            endcase
            n_checks++;
            if (e.due != cyc || ag !== e.gate || agv !== (|e.gate) || ao !== e.owner ||
                (e.chk_hold && ah !== e.hold)) begin
                n_fail++;
                $display("FAIL %s (dut %0d cyc %0d): got gate=%b gv=%b owner=%0d hold=%0d, want gate=%b owner=%0d hold=%0d",
                         e.name, e.dut, cyc, ag, agv, ao, ah, e.gate, e.owner,
                         e.chk_hold ? int'(e.hold) : -1);
            end
        end
    end

    // Per-cycle invariants on every instance.
    logic [3:0] prev_a = '0, prev_b = '0;

    task automatic inv(input string name, input logic [3:0] g, input logic gv,
                       input logic [3:0] prev, input bit no_direct);
        n_checks++;
        if (!$onehot0(g) || gv !== (|g) ||
            (no_direct && prev != '0 && g != '0 && g != prev)) begin
            n_fail++;
            $display("FAIL inv_%s: got gate=%b gv=%b prev=%b, want one-hot/zero, gv==|gate",
                     name, g, gv, prev);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            inv("a", gate_a, gv_a, prev_a, 1'b1);
            inv("b", gate_b, gv_b, prev_b, 1'b1);
            inv("c", gate_c, gv_c, 4'b0000, 1'b0);
        end
        prev_a = gate_a;
        prev_b = gate_b;
    end

    // Round-robin table for B (Req=1111, MAX_HOLD=2).
    logic [3:0] rr_gate [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                 4'b0001};
    int         rr_own  [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int         rr_hold [13] = '{1, 2, -1, 1, 2, -1, 1, 2, -1, 1, 2, -1, 1};

    // Starvation table for A (PC held, MARMUX raised at cycle 3).
    logic [3:0] sv_req  [15] = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
                                 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] sv_gate [15] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                                 4'b1000, 4'b0000, 4'b0000};
    int         sv_own  [15] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 3, 3, 3};
    int         sv_hold [15] = '{1, 2, 3, 4, 5, 6, 7, 8, -1, 1, 2, -1, 1, -1, -1};

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state on every instance.
        step(0, 4'b0000, 4'b0000, 3, 0, "reset_a");
        step(1, 4'b0000, 4'b0000, 3, 0, "reset_b");
        step(2, 4'b0000, 4'b0000, 3, 0, "reset_c");

        // Single request: 1-cycle latency, hold 1..5, then TURN and IDLE.
        for (int i = 1; i <= 5; i++) step(0, 4'b0100, 4'b0100, 2, i, "single_hold");
        step(0, 4'b0000, 4'b0000, 2, -1, "single_turn");
        step(0, 4'b0000, 4'b0000, 2, -1, "single_idle");

        // Asynchronous reset during GRANT clears Gate without an edge.
        step(0, 4'b0100, 4'b0100, 2, 1, "pre_reset_grant");
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gate_a !== 4'b0000 || gv_a !== 1'b0 || owner_a !== 2'd3) begin
            n_fail++;
            $display("FAIL async_reset: got gate=%b gv=%b owner=%0d, want gate=0000 gv=0 owner=3",
                     gate_a, gv_a, owner_a);
        end
        req_a = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 4'b0000, 4'b0000, 3, 0, "after_reset_idle");

        // Lone requester saturates at MAX_HOLD without being released.
        for (int i = 1; i <= 20; i++) step(0, 4'b0010, 4'b0010, 1, (i > 8) ? 8 : i, "saturate");
        step(0, 4'b0000, 4'b0000, 1, -1, "saturate_turn");
        step(0, 4'b0000, 4'b0000, 1, -1, "saturate_idle");

        // Starvation bound.
        for (int i = 0; i < 15; i++) step(0, sv_req[i], sv_gate[i], 2'(sv_own[i]), sv_hold[i], "starve");

        // Round-robin with dead cycles.
        for (int i = 0; i < 13; i++) step(1, 4'b1111, rr_gate[i], 2'(rr_own[i]), rr_hold[i], "round_robin");
        step(1, 4'b0000, 4'b0000, 0, -1, "rr_turn");
        step(1, 4'b0000, 4'b0000, 0, -1, "rr_idle");

        // No turnaround: direct owner-to-owner switch.
        step(2, 4'b0100, 4'b0100, 2, 1, "direct_grant");
        step(2, 4'b0100, 4'b0100, 2, 2, "direct_hold");
        step(2, 4'b1000, 4'b1000, 3, 1, "direct_switch");
        step(2, 4'b1000, 4'b1000, 3, 2, "direct_hold2");
        step(2, 4'b0000, 4'b0000, 3, -1, "direct_idle");

        repeat (3) @(posedge clk);
        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
